// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the single-port byte-enabled data memory.
// Turns a core request (byte/half/word, any byte address) into one or two memory
// beats with byte enables and lane-shifted write data, then returns load data
// reassembled and sign/zero-extended in a one-cycle response.
// Build option: define LSU_MISALIGN_EN to execute word-crossing accesses as two
// beats; when undefined, such requests are rejected with rsp_err_o and memory is untouched.
module lsu_mem_master #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_write_o,
    output logic [3:0]        mem_be_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LO, S_RESP} state_t;
`endif

    state_t            state_q, state_d;

    logic              write_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;

    logic [1:0]        off;
    logic [3:0]        mask_base;
    logic [ADDR_W-1:0] lo_addr;
    logic [3:0]        lo_be;
    logic [31:0]       lo_data;
    logic [31:0]       rd_word;
    logic [31:0]       rd_ext;
    logic [31:0]       rsp_data_now;

`ifdef LSU_MISALIGN_EN
    logic [31:0]       hi_q;
    logic              split;
    logic [7:0]        mask8;
    logic [63:0]       wide;
    logic [ADDR_W-3:0] hi_word;
    logic [ADDR_W-1:0] hi_addr;
`else
    logic              err_q;
    logic              rsp_err_q;
    logic [2:0]        req_nbytes;
    logic              req_split;
`endif

    // Beat addresses, byte enables, lane-shifted store data and load reassembly
    always_comb begin
        off = addr_q[1:0];
        case (size_q)
            2'b00:   mask_base = 4'b0001;
            2'b01:   mask_base = 4'b0011;
            default: mask_base = 4'b1111;
        endcase
        lo_addr = {addr_q[ADDR_W-1:2], 2'b00};
`ifdef LSU_MISALIGN_EN
        mask8   = {4'b0000, mask_base} << off;
        wide    = {32'b0, wdata_q} << {off, 3'b000};
        // Any enable spilling into the upper nibble means off + nbytes > 4
        split   = |mask8[7:4];
        hi_word = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
        hi_addr = {hi_word, 2'b00};
        lo_be   = mask8[3:0];
        lo_data = wide[31:0];
        rd_word = 32'({hi_q, lo_q} >> {off, 3'b000});
`else
        // Only non-split requests reach a beat, so no lane is shifted out here
        lo_be   = mask_base << off;
        lo_data = wdata_q << {off, 3'b000};
        rd_word = lo_q >> {off, 3'b000};
`endif
        case (size_q)
            2'b00:   rd_ext = signed_q ? {{24{rd_word[7]}}, rd_word[7:0]}
                                       : {24'b0, rd_word[7:0]};
            2'b01:   rd_ext = signed_q ? {{16{rd_word[15]}}, rd_word[15:0]}
                                       : {16'b0, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
`ifdef LSU_MISALIGN_EN
        rsp_data_now = write_q ? '0 : rd_ext;
`else
        rsp_data_now = (write_q || err_q) ? '0 : rd_ext;
`endif
    end

`ifndef LSU_MISALIGN_EN
    // Classify the incoming request as word-crossing so it can be rejected at accept
    always_comb begin
        case (req_size_i)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_split = ({1'b0, req_addr_i[1:0]} + req_nbytes) > 3'd4;
    end
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
`ifdef LSU_MISALIGN_EN
                    state_d = S_LO;
`else
                    state_d = req_split ? S_RESP : S_LO;
`endif
                end
            end
`ifdef LSU_MISALIGN_EN
            S_LO:    state_d = split ? S_HI : S_RESP;
            S_HI:    state_d = S_RESP;
`else
            S_LO:    state_d = S_RESP;
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, load-word capture and held bus/response values
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
`ifdef LSU_MISALIGN_EN
            hi_q       <= '0;
`else
            err_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        write_q  <= req_write_i;
                        signed_q <= req_signed_i;
                        size_q   <= req_size_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
`ifdef LSU_MISALIGN_EN
                        hi_q     <= '0;
`else
                        err_q    <= req_split;
`endif
                    end
                end
                S_LO: begin
                    mem_addr_q <= lo_addr;
                    mem_data_q <= lo_data;
                    if (!write_q) begin
                        lo_q <= mem_data_i;
                    end
                end
`ifdef LSU_MISALIGN_EN
                S_HI: begin
                    mem_addr_q <= hi_addr;
                    mem_data_q <= wide[63:32];
                    if (!write_q) begin
                        hi_q <= mem_data_i;
                    end
                end
`endif
                S_RESP: begin
                    rdata_q <= rsp_data_now;
`ifndef LSU_MISALIGN_EN
                    rsp_err_q <= err_q;
`endif
                end
                default: ;
            endcase
        end
    end

    // Output decode: memory beat drive, handshake and response
    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        rsp_valid_o  = (state_q == S_RESP);
        rsp_rdata_o  = rdata_q;
        mem_write_o  = 1'b0;
        mem_be_sel_o = '0;
        mem_addr_o   = mem_addr_q;
        mem_data_o   = mem_data_q;
`ifndef LSU_MISALIGN_EN
        rsp_err_o    = rsp_err_q;
`endif
        case (state_q)
            S_LO: begin
                mem_write_o  = write_q;
                mem_be_sel_o = lo_be;
                mem_addr_o   = lo_addr;
                mem_data_o   = lo_data;
            end
`ifdef LSU_MISALIGN_EN
            S_HI: begin
                mem_write_o  = write_q;
                mem_be_sel_o = mask8[7:4];
                mem_addr_o   = hi_addr;
                mem_data_o   = wide[63:32];
            end
`endif
            S_RESP: begin
                rsp_rdata_o = rsp_data_now;
`ifndef LSU_MISALIGN_EN
                rsp_err_o   = err_q;
`endif
            end
            default: ;
        endcase
        // No write may commit in a cycle where reset is asserted
        if (!rst_i) begin
            mem_write_o  = 1'b0;
            mem_be_sel_o = '0;
        end
    end

`ifdef LSU_MISALIGN_EN
    assign rsp_err_o = 1'b0;
`endif

endmodule
